// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports, N read ports, optional
// write-to-read forwarding, hardwired zero register and a busy scoreboard.
module regfile_mp #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NRD*DATA_WIDTH-1:0] rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic                      wa_en,
    input  logic [ADDR_WIDTH-1:0]     wa_addr,
    input  logic [DATA_WIDTH-1:0]     wa_data,
    input  logic                      wb_en,
    input  logic [ADDR_WIDTH-1:0]     wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      iss_en,
    input  logic [ADDR_WIDTH-1:0]     iss_addr,
    input  logic                      flush,
    output logic [ADDR_WIDTH:0]       busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic [CW-1:0]         cnt_next;
    logic                  wa_ok;
    logic                  wb_ok;

    // Writes to the hardwired zero register are dropped before anything sees them
    assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
    assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    // Scoreboard update: flush, then write-clear, then issue-set (issue wins)
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush) begin
                busy_next[i] = 1'b0;
            end
            if ((wa_ok && (wa_addr == ADDR_WIDTH'(i))) ||
                (wb_ok && (wb_addr == ADDR_WIDTH'(i)))) begin
                busy_next[i] = 1'b0;
            end
            if (iss_en && (iss_addr == ADDR_WIDTH'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_next = cnt_next + CW'(busy_next[i]);
        end
    end

    // Array, busy bits and count; port B overrides port A on address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wb_ok && (wb_addr == ADDR_WIDTH'(i))) begin
                    regs[i] <= wb_data;
                end else if (wa_ok && (wa_addr == ADDR_WIDTH'(i))) begin
                    regs[i] <= wa_data;
                end
            end
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Zero-latency read with optional forwarding of same-cycle writes
        always_comb begin
            data = regs[ra];
            bsy  = busy[ra];
            if (BYPASS != 0) begin
                if (wb_ok && (wb_addr == ra)) begin
                    data = wb_data;
                    bsy  = 1'b0;
                end else if (wa_ok && (wa_addr == ra)) begin
                    data = wa_data;
                    bsy  = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[k]                          = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding instance and a non-forwarding instance
// share stimulus; expected values are queued at drive time and popped on check.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] rd_data_nb;
    logic [1:0]  rd_busy;
    logic [1:0]  rd_busy_nb;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic [5:0]  busy_cnt_nb;

    int          checks;
    int          errors;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset;
        // Enables held during reset must leave no trace
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234_5678;
        iss_en = 1'b1; iss_addr = 5'd5; flush = 1'b1;
        repeat (2) step();
        idle();
        #2 rst_n = 1'b1;
        rd_addr = {5'd0, 5'd5};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL reset_rd0 got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd_data[63:32], e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy) !== e) begin errors++; $display("FAIL reset_busy got %h exp %h", rd_busy, e); end
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL reset_cnt got %0d exp %0d", busy_cnt, e); end
    endtask

    task automatic test_bypass;
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEAD_BEEF;
        rd_addr = {5'd0, 5'd3};
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL bypass_same got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data_nb[31:0] !== e) begin errors++; $display("FAIL nobypass_same got %h exp %h", rd_data_nb[31:0], e); end
        step();
        idle();
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL bypass_next got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data_nb[31:0] !== e) begin errors++; $display("FAIL nobypass_next got %h exp %h", rd_data_nb[31:0], e); end
    endtask

    task automatic test_collision;
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        rd_addr = {5'd0, 5'd7};
        exp_q.push_back(32'h22);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL coll_fwd got %h exp %h", rd_data[31:0], e); end
        step();
        idle();
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h55;
        rd_addr = {5'd0, 5'd7};
        exp_q.push_back(32'h22); exp_q.push_back(32'h22); exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL coll_x7 got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data_nb[31:0] !== e) begin errors++; $display("FAIL coll_x7_nb got %h exp %h", rd_data_nb[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL zero_fwd got %h exp %h", rd_data[63:32], e); end
        step();
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL zero_rd got %h exp %h", rd_data[63:32], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data_nb[63:32] !== e) begin errors++; $display("FAIL zero_rd_nb got %h exp %h", rd_data_nb[63:32], e); end
    endtask

    task automatic test_busy;
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        idle();
        rd_addr = {5'd0, 5'd4};
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy[0]) !== e) begin errors++; $display("FAIL busy_set got %0d exp %0d", rd_busy[0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL busy_cnt1 got %0d exp %0d", busy_cnt, e); end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h99;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy[0]) !== e) begin errors++; $display("FAIL busy_fwd_clr got %0d exp %0d", rd_busy[0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy_nb[0]) !== e) begin errors++; $display("FAIL busy_nb_hold got %0d exp %0d", rd_busy_nb[0], e); end
        step();
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h99);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL busy_cnt0 got %0d exp %0d", busy_cnt, e); end
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL busy_wdata got %h exp %h", rd_data[31:0], e); end
        iss_en = 1'b1; iss_addr = 5'd4;
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h77;
        step();
        idle();
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h77);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy[0]) !== e) begin errors++; $display("FAIL iss_wins got %0d exp %0d", rd_busy[0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL iss_wins_cnt got %0d exp %0d", busy_cnt, e); end
        checks++; e = exp_q.pop_front();
        if (rd_data_nb[31:0] !== e) begin errors++; $display("FAIL iss_wins_data got %h exp %h", rd_data_nb[31:0], e); end
        // Re-issue of an already busy register does not stack
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        idle();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h78;
        step();
        idle();
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL reissue_cnt got %0d exp %0d", busy_cnt, e); end
    endtask

    task automatic test_flush;
        for (int i = 1; i <= 3; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            step();
        end
        idle();
        exp_q.push_back(32'h3);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL flush_pre_cnt got %0d exp %0d", busy_cnt, e); end
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd9;
        wa_en = 1'b1; wa_addr = 5'd2; wa_data = 32'h2222;
        step();
        idle();
        rd_addr = {5'd2, 5'd9};
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h2222);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", busy_cnt, e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy[0]) !== e) begin errors++; $display("FAIL flush_x9 got %0d exp %0d", rd_busy[0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy[1]) !== e) begin errors++; $display("FAIL flush_x2 got %0d exp %0d", rd_busy[1], e); end
        checks++; e = exp_q.pop_front();
        if (rd_data[63:32] !== e) begin errors++; $display("FAIL flush_wr got %h exp %h", rd_data[63:32], e); end
    endtask

    task automatic test_ooo_and_zero;
        wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'hCAFE;
        step();
        idle();
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        idle();
        rd_addr = {5'd0, 5'd10};
        exp_q.push_back(32'hCAFE); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL ooo_data got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy[0]) !== e) begin errors++; $display("FAIL ooo_busy got %0d exp %0d", rd_busy[0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy_nb[1]) !== e) begin errors++; $display("FAIL zero_busy got %0d exp %0d", rd_busy_nb[1], e); end
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL zero_cnt got %0d exp %0d", busy_cnt, e); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        for (int i = 11; i <= 14; i++) begin
            v = $urandom;
            wa_en = 1'b1; wa_addr = 5'(i); wa_data = v;
            wb_en = 1'b1; wb_addr = 5'(i + 8); wb_data = ~v;
            exp_q.push_back(v);
            exp_q.push_back(~v);
            step();
        end
        idle();
        for (int i = 11; i <= 14; i++) begin
            rd_addr = {5'(i + 8), 5'(i)};
            #1;
            checks++; e = exp_q.pop_front();
            if (rd_data_nb[31:0] !== e) begin errors++; $display("FAIL b2b_a x%0d got %h exp %h", i, rd_data_nb[31:0], e); end
            checks++; e = exp_q.pop_front();
            if (rd_data_nb[63:32] !== e) begin errors++; $display("FAIL b2b_b x%0d got %h exp %h", i + 8, rd_data_nb[63:32], e); end
        end
    endtask

    task automatic test_async_reset;
        iss_en = 1'b1; iss_addr = 5'd6;
        wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'hAB;
        step();
        idle();
        rd_addr = {5'd9, 5'd6};
        exp_q.push_back(32'hAB); exp_q.push_back(32'h2);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL arst_pre_data got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL arst_pre_cnt got %0d exp %0d", busy_cnt, e); end
        // Reset lands mid-cycle with a write pending on the next edge
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hFF;
        #1 rst_n = 1'b0;
        wb_en = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL arst_data got %h exp %h", rd_data[31:0], e); end
        checks++; e = exp_q.pop_front();
        if (32'(rd_busy) !== e) begin errors++; $display("FAIL arst_busy got %h exp %h", rd_busy, e); end
        checks++; e = exp_q.pop_front();
        if (32'(busy_cnt) !== e) begin errors++; $display("FAIL arst_cnt got %0d exp %0d", busy_cnt, e); end
        step();
        #2 rst_n = 1'b1;
        step();
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data[31:0] !== e) begin errors++; $display("FAIL arst_after got %h exp %h", rd_data[31:0], e); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wa_en    = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en    = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en   = 1'b0; iss_addr = '0;
        flush    = 1'b0;
        #2;
        test_reset();
        step();
        test_bypass();
        test_collision();
        test_busy();
        test_flush();
        test_ooo_and_zero();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
